tcdm_apb_bridge: RTL and testbench
==================================

Name: tcdm_apb_bridge

Overview:
- Converts single-beat TCDM-style requests from the SoC interconnect into APB4 transfers.
- Drives the APB slave port of the peripheral bus wrapper.
- One outstanding transaction; address decode stays downstream.
- Adds an alignment check and a configurable ACCESS-phase timeout, so a hung peripheral returns an error instead of stalling the core.

Parameters:
- APB_ADDR_WIDTH, 32, width of add_i and paddr_o.
- APB_DATA_WIDTH, 32, data width; fixed at 32, byte enables are 4 bits.
- TIMEOUT_CYCLES, 255, maximum ACCESS-phase cycles before abort; 0 disables the timeout.
- ERR_RDATA, 32'hBADACCE5, r_rdata_o value on any error response.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-high reset
- req_i  in  1  request valid
- add_i  in  APB_ADDR_WIDTH  byte address
- wen_i  in  1  1 = read, 0 = write
- be_i  in  4  byte enables (writes only)
- wdata_i  in  32  write data
- gnt_o  out  1  request accepted
- r_valid_o  out  1  response valid, one-cycle pulse
- r_rdata_o  out  32  read data
- r_opc_o  out  1  1 = error response
- paddr_o  out  APB_ADDR_WIDTH  APB address
- pwdata_o  out  32  APB write data
- pwrite_o  out  1  APB write
- pstrb_o  out  4  APB4 strobes
- psel_o  out  1  APB select
- penable_o  out  1  APB enable
- prdata_i  in  32  APB read data
- pready_i  in  1  APB ready
- pslverr_i  in  1  APB slave error

Behaviour:
- Reset: all outputs 0, FSM in IDLE, timeout counter 0. Reset takes effect immediately, including mid-transfer; psel_o and penable_o drop asynchronously and no response is issued for the aborted request.
- FSM has four states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - gnt_o = req_i, combinational, asserted only in IDLE.
  - On req_i the block registers add_i, wen_i, be_i and wdata_i.
  - If add_i[1:0] != 0, go to RESP with error; no APB transfer is issued.
  - Otherwise go to SETUP.
- SETUP (one cycle): psel_o=1, penable_o=0, paddr_o=latched address, pwrite_o=~wen, pwdata_o=latched wdata.
  - pstrb_o = latched be on writes, 4'h0 on reads.
  - Next state is ACCESS.
- ACCESS: psel_o=1, penable_o=1. All APB outputs hold stable until exit.
  - Cycle with pready_i=1: capture prdata_i (reads) and pslverr_i, then go to RESP.
  - Timeout counter increments each ACCESS cycle with pready_i=0.
  - If TIMEOUT_CYCLES != 0 and the counter reaches TIMEOUT_CYCLES, abort: drop psel/penable, go to RESP with error.
  - pready_i=1 in the same cycle as expiry counts as completion, not timeout.
  - Counter clears on exit from ACCESS.
- RESP (one cycle): r_valid_o=1, then return to IDLE.
  - r_opc_o=1 for misalignment, pslverr_i or timeout; r_rdata_o=ERR_RDATA for any error.
  - Successful read: r_rdata_o = captured prdata. Successful write: r_rdata_o = 0, r_opc_o = 0.
  - gnt_o=0 in RESP; a new request is grantable the cycle after RESP.
- Latency: grant cycle 0 -> SETUP cycle 1 -> ACCESS cycle 2 -> (pready at cycle 2) -> r_valid_o at cycle 3. Back-to-back throughput is one transfer per 4 cycles at zero wait states.
- Outputs r_rdata_o, r_opc_o, paddr_o, pwdata_o, pwrite_o and pstrb_o are registered. psel_o and penable_o are decoded from the state register.
- Write with be_i=4'h0 is still issued on APB with pstrb_o=0.
- Read ignores be_i.
- Inputs are ignored outside IDLE; a held req_i is re-granted only on return to IDLE.

Test Plan:
- Read 0x1A10_4000, prdata=0x1234_5678, pready high in ACCESS -> gnt cycle 0, psel cycle 1, penable cycle 2, r_valid cycle 3, rdata=0x12345678, opc=0.
- Write 0x1A10_1004, wdata=0xCAFE_F00D, be=4'b0011, pready after 3 wait states -> pwrite=1, pstrb=0011, inputs stable 4 ACCESS cycles, r_valid cycle 6, opc=0.
- Read 0x1A10_2002 (misaligned) -> psel never asserted, r_valid cycle 1, opc=1, rdata=0xBADACCE5.
- TIMEOUT_CYCLES=4, pready stuck low -> penable high exactly 4 cycles, then r_valid with opc=1, rdata=0xBADACCE5. Repeat with pready=1 on the 4th ACCESS cycle -> normal completion.
- pslverr=1 with pready on a read -> opc=1, rdata=0xBADACCE5. Next held request re-granted the cycle after RESP.
- Assert rst_i during ACCESS -> psel/penable drop the same cycle, no r_valid. After release, a new read completes normally.

Source files
------------

// File: rtl/tcdm_apb_bridge.sv
// Single-beat TCDM request to APB4 transfer bridge with one outstanding request,
// word-alignment checking and an optional ACCESS-phase timeout.
module tcdm_apb_bridge #(
  parameter int                          APB_ADDR_WIDTH = 32,
  parameter int                          APB_DATA_WIDTH = 32,
  parameter int                          TIMEOUT_CYCLES = 255,
  parameter logic [APB_DATA_WIDTH-1:0]   ERR_RDATA      = 32'hBADACCE5
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       req_i,
  input  logic [APB_ADDR_WIDTH-1:0]  add_i,
  input  logic                       wen_i,
  input  logic [3:0]                 be_i,
  input  logic [APB_DATA_WIDTH-1:0]  wdata_i,
  output logic                       gnt_o,
  output logic                       r_valid_o,
  output logic [APB_DATA_WIDTH-1:0]  r_rdata_o,
  output logic                       r_opc_o,
  output logic [APB_ADDR_WIDTH-1:0]  paddr_o,
  output logic [APB_DATA_WIDTH-1:0]  pwdata_o,
  output logic                       pwrite_o,
  output logic [3:0]                 pstrb_o,
  output logic                       psel_o,
  output logic                       penable_o,
  input  logic [APB_DATA_WIDTH-1:0]  prdata_i,
  input  logic                       pready_i,
  input  logic                       pslverr_i
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic             TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  state_e                      state_q, state_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [APB_ADDR_WIDTH-1:0]   paddr_q, paddr_d;
  logic [APB_DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
  logic                        pwrite_q, pwrite_d;
  logic [3:0]                  pstrb_q, pstrb_d;
  logic [APB_DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                        opc_q, opc_d;
  logic                        expire;

  // A pready in the expiry cycle wins, so expiry is only evaluated when pready_i is low.
  assign expire = TIMEOUT_EN && (cnt_q == CNT_LAST);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    pwrite_d = pwrite_q;
    pstrb_d  = pstrb_q;
    rdata_d  = rdata_q;
    opc_d    = opc_q;
    case (state_q)
      IDLE: begin
        if (req_i) begin
          paddr_d  = add_i;
          pwdata_d = wdata_i;
          pwrite_d = ~wen_i;
          pstrb_d  = wen_i ? 4'h0 : be_i;
          if (add_i[1:0] != 2'b00) begin
            state_d = RESP;
            opc_d   = 1'b1;
            rdata_d = ERR_RDATA;
          end else begin
            state_d = SETUP;
          end
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        if (pready_i) begin
          state_d = RESP;
          cnt_d   = '0;
          opc_d   = pslverr_i;
          rdata_d = pslverr_i ? ERR_RDATA : (pwrite_q ? '0 : prdata_i);
        end else if (expire) begin
          state_d = RESP;
          cnt_d   = '0;
          opc_d   = 1'b1;
          rdata_d = ERR_RDATA;
        end else if (TIMEOUT_EN) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
        opc_d   = 1'b0;
        rdata_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      paddr_q  <= '0;
      pwdata_q <= '0;
      pwrite_q <= 1'b0;
      pstrb_q  <= 4'h0;
      rdata_q  <= '0;
      opc_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      pwrite_q <= pwrite_d;
      pstrb_q  <= pstrb_d;
      rdata_q  <= rdata_d;
      opc_q    <= opc_d;
    end
  end

  // Handshake: a request is taken in any IDLE cycle where req_i is high (gnt_o = req_i);
  // exactly one r_valid_o pulse follows each grant unless reset intervenes.
  assign gnt_o     = (state_q == IDLE) && req_i;
  assign psel_o    = (state_q == SETUP) || (state_q == ACCESS);
  assign penable_o = (state_q == ACCESS);
  assign r_valid_o = (state_q == RESP);
  assign r_rdata_o = rdata_q;
  assign r_opc_o   = opc_q;
  assign paddr_o   = paddr_q;
  assign pwdata_o  = pwdata_q;
  assign pwrite_o  = pwrite_q;
  assign pstrb_o   = pstrb_q;

endmodule

// File: tb/tb_tcdm_apb_bridge.sv
// Bench for tcdm_apb_bridge: vector table plus hand-written reset/hold sequences,
// responses checked against a scoreboard queue.
module tb_tcdm_apb_bridge;

  localparam int          TO  = 4;
  localparam logic [31:0] ERR = 32'hBADACCE5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic [31:0] add = '0;
  logic        wen = 1'b0;
  logic [3:0]  be = '0;
  logic [31:0] wdata = '0;
  logic        gnt, r_valid, r_opc, pwrite, psel, penable;
  logic [31:0] r_rdata, paddr, pwdata;
  logic [3:0]  pstrb;
  logic [31:0] prdata = '0;
  logic        pready = 1'b0;
  logic        pslverr = 1'b0;

  tcdm_apb_bridge #(
    .APB_ADDR_WIDTH(32),
    .APB_DATA_WIDTH(32),
    .TIMEOUT_CYCLES(TO),
    .ERR_RDATA(ERR)
  ) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .add_i(add), .wen_i(wen), .be_i(be),
    .wdata_i(wdata), .gnt_o(gnt), .r_valid_o(r_valid), .r_rdata_o(r_rdata),
    .r_opc_o(r_opc), .paddr_o(paddr), .pwdata_o(pwdata), .pwrite_o(pwrite),
    .pstrb_o(pstrb), .psel_o(psel), .penable_o(penable), .prdata_i(prdata),
    .pready_i(pready), .pslverr_i(pslverr)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    logic        rd;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] prdata;
    int          waits;
    logic        hang;
    logic        slverr;
    logic        hold;
    logic        exp_opc;
    logic [31:0] exp_rdata;
    int          exp_cyc;
    int          exp_pen;
    logic [3:0]  exp_pstrb;
  } vec_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [32:0] exp_q[$];
  vec_t        vecs[10];

  function automatic vec_t mk(input logic rd, input logic [31:0] addr, input logic [3:0] be,
                              input logic [31:0] wd, input logic [31:0] prd, input int waits,
                              input logic hang, input logic slverr, input logic hold,
                              input logic eopc, input logic [31:0] erd, input int ecyc,
                              input int epen, input logic [3:0] estrb);
    vec_t v;
    v.rd = rd; v.addr = addr; v.be = be; v.wdata = wd; v.prdata = prd; v.waits = waits;
    v.hang = hang; v.slverr = slverr; v.hold = hold; v.exp_opc = eopc; v.exp_rdata = erd;
    v.exp_cyc = ecyc; v.exp_pen = epen; v.exp_pstrb = estrb;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Entered at a negedge in an IDLE cycle; returns at the negedge of the cycle after RESP.
  task automatic run_txn(input vec_t v);
    int          acc_n;
    logic        done;
    logic        apb_ok;
    logic        psel_seen;
    logic [32:0] sb;
    acc_n = 0; done = 1'b0; apb_ok = 1'b1; psel_seen = 1'b0;
    req = 1'b1; add = v.addr; wen = v.rd; be = v.be; wdata = v.wdata;
    pready = 1'b0; pslverr = 1'b0;
    #1;
    check("gnt_on_req", gnt, 1);
    exp_q.push_back({v.exp_opc, v.exp_rdata});
    for (int cyc = 1; cyc <= 30 && !done; cyc++) begin
      @(posedge clk);
      @(negedge clk);
      if (!v.hold) req = 1'b0;
      else check("gnt_held_busy", gnt, 0);
      if (psel) psel_seen = 1'b1;
      if (psel && (paddr !== v.addr || pwrite !== ~v.rd || pstrb !== v.exp_pstrb ||
                   pwdata !== v.wdata)) apb_ok = 1'b0;
      if (penable && !psel) apb_ok = 1'b0;
      if (r_valid) begin
        done = 1'b1;
        check("resp_cycle", cyc, v.exp_cyc);
        if (exp_q.size() == 0) begin
          check("resp_unexpected", 1, 0);
        end else begin
          sb = exp_q.pop_front();
          check("resp_opc", r_opc, sb[32]);
          check("resp_rdata", r_rdata, sb[31:0]);
        end
      end
      if (penable) begin
        acc_n++;
        pready  = !v.hang && (acc_n == v.waits + 1);
        prdata  = v.prdata;
        pslverr = v.slverr && pready;
      end else begin
        pready  = 1'b0;
        pslverr = 1'b0;
      end
    end
    check("resp_seen", done, 1);
    check("penable_cycles", acc_n, v.exp_pen);
    check("psel_seen", psel_seen, v.exp_pen != 0);
    check("apb_stable", apb_ok, 1);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    //            rd  addr          be     wdata          prdata         w  hang slv hold opc rdata          cyc pen strb
    vecs[0] = mk(1, 32'h1A10_4000, 4'hF, 32'h0,         32'h1234_5678, 0, 0, 0, 0, 0, 32'h1234_5678, 3, 1, 4'h0);
    vecs[1] = mk(0, 32'h1A10_1004, 4'h3, 32'hCAFE_F00D, 32'hFFFF_FFFF, 3, 0, 0, 0, 0, 32'h0,         6, 4, 4'h3);
    vecs[2] = mk(1, 32'h1A10_2002, 4'hF, 32'h0,         32'h5555_5555, 0, 0, 0, 0, 1, ERR,           1, 0, 4'h0);
    vecs[3] = mk(1, 32'h1A10_3000, 4'h0, 32'h0,         32'h7777_7777, 0, 1, 0, 0, 1, ERR,           6, 4, 4'h0);
    vecs[4] = mk(1, 32'h1A10_3004, 4'h0, 32'h0,         32'hA5A5_0F0F, 3, 0, 0, 0, 0, 32'hA5A5_0F0F, 6, 4, 4'h0);
    vecs[5] = mk(1, 32'h1A10_5000, 4'hF, 32'h0,         32'h1111_2222, 0, 0, 1, 1, 1, ERR,           3, 1, 4'h0);
    vecs[6] = mk(0, 32'h1A10_0010, 4'h0, 32'h0BAD_F00D, 32'h0,         1, 0, 0, 0, 0, 32'h0,         4, 2, 4'h0);
    vecs[7] = mk(1, 32'h1A10_0020, 4'hF, 32'h1357_9BDF, 32'hDEAD_BEEF, 1, 0, 0, 0, 0, 32'hDEAD_BEEF, 4, 2, 4'h0);
    vecs[8] = mk(0, 32'h1A10_0001, 4'hF, 32'h2468_ACE0, 32'h0,         0, 0, 0, 0, 1, ERR,           1, 0, 4'h0);
    vecs[9] = mk(0, 32'h1A10_0030, 4'hC, 32'h8765_4321, 32'h0,         2, 0, 1, 0, 1, ERR,           5, 3, 4'hC);

    @(negedge clk);
    check("rst_psel", psel, 0);
    check("rst_penable", penable, 0);
    check("rst_r_valid", r_valid, 0);
    check("rst_gnt", gnt, 0);
    check("rst_regs", {paddr, pwdata, pwrite, pstrb, r_rdata, r_opc}, '0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 10; i++) run_txn(vecs[i]);

    for (int i = 0; i < 6; i++) begin
      vec_t v;
      int   w;
      logic [31:0] d;
      w = $urandom_range(0, 3);
      d = $urandom();
      v = mk(1, $urandom() & 32'hFFFF_FFFC, 4'($urandom_range(0, 15)), $urandom(), d, w,
             0, 0, 0, 0, d, 3 + w, w + 1, 4'h0);
      run_txn(v);
    end

    // Reset in the middle of an ACCESS phase.
    req = 1'b1; add = 32'h1A10_0040; wen = 1'b1; be = 4'hF; pready = 1'b0;
    @(posedge clk); @(negedge clk);
    req = 1'b0;
    @(posedge clk); @(negedge clk);
    check("mid_access_penable", penable, 1);
    rst = 1'b1;
    #1;
    check("rst_async_psel", psel, 0);
    check("rst_async_penable", penable, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_no_rvalid", r_valid, 0);
    end
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_no_rvalid", r_valid, 0);
    run_txn(vecs[0]);

    check("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
